// File: rtl/isq_pkg.sv
// Shared defaults and entry layout for the issue-queue entry controller.
// ISSUE_QUEUE_DEPTH / ISSUE_QUEUE_LOG may be overridden on the command line.
`ifndef ISSUE_QUEUE_DEPTH
`define ISSUE_QUEUE_DEPTH 8
`endif
`ifndef ISSUE_QUEUE_LOG
`define ISSUE_QUEUE_LOG 3
`endif

package isq_pkg;

  localparam int ISQ_DEPTH     = `ISSUE_QUEUE_DEPTH;
  localparam int ISQ_LOG       = `ISSUE_QUEUE_LOG;
  localparam int ISQ_PREG_W    = 6;
  localparam int ISQ_PAYLOAD_W = 64;

  typedef struct packed {
    logic                     valid;
    logic [ISQ_PREG_W-1:0]    src1_tag;
    logic [ISQ_PREG_W-1:0]    src2_tag;
    logic                     src1_rdy;
    logic                     src2_rdy;
    logic [ISQ_PAYLOAD_W-1:0] payload;
  } isq_entry_t;

endpackage

// File: rtl/isq_entry_ctrl_if.sv
// Enqueue / wakeup / age-policy / issue bundle of the issue-queue entry controller.
interface isq_entry_ctrl_if
  import isq_pkg::*;
#(
  parameter int DEPTH     = ISQ_DEPTH,
  parameter int LOG       = ISQ_LOG,
  parameter int PREG_W    = ISQ_PREG_W,
  parameter int PAYLOAD_W = ISQ_PAYLOAD_W
);
  logic                 enq_valid;
  logic                 enq_ready;
  logic [PREG_W-1:0]    enq_src1_preg;
  logic [PREG_W-1:0]    enq_src2_preg;
  logic                 enq_src1_rdy;
  logic                 enq_src2_rdy;
  logic [PAYLOAD_W-1:0] enq_payload;
  logic                 wb_valid;
  logic [PREG_W-1:0]    wb_preg;
  logic                 flush_valid;
  logic                 oldest_found;
  logic [DEPTH-1:0]     oldest_idx_oh;
  logic                 deq_valid;
  logic                 deq_ready;
  logic [PAYLOAD_W-1:0] deq_payload;
  logic [DEPTH-1:0]     iq_entries_valid;
  logic [DEPTH-1:0]     iq_entries_ready_to_go;
  logic [DEPTH-1:0]     iq_entries_wren_oh;
  logic [LOG-1:0]       enq_ptr;
  logic [DEPTH-1:0]     iq_entries_clear_entry;
  logic [LOG-1:0]       deq_ptr;

  modport master (
    output enq_valid, enq_src1_preg, enq_src2_preg, enq_src1_rdy, enq_src2_rdy,
           enq_payload, wb_valid, wb_preg, flush_valid, oldest_found,
           oldest_idx_oh, deq_ready,
    input  enq_ready, deq_valid, deq_payload, iq_entries_valid,
           iq_entries_ready_to_go, iq_entries_wren_oh, enq_ptr,
           iq_entries_clear_entry, deq_ptr
  );

  modport slave (
    input  enq_valid, enq_src1_preg, enq_src2_preg, enq_src1_rdy, enq_src2_rdy,
           enq_payload, wb_valid, wb_preg, flush_valid, oldest_found,
           oldest_idx_oh, deq_ready,
    output enq_ready, deq_valid, deq_payload, iq_entries_valid,
           iq_entries_ready_to_go, iq_entries_wren_oh, enq_ptr,
           iq_entries_clear_entry, deq_ptr
  );
endinterface

// File: rtl/isq_free_finder.sv
// Lowest-set-bit finder: one-hot, binary index and found flag (index 0 when none).
module isq_free_finder #(
  parameter int DEPTH = 8,
  parameter int LOG   = 3
) (
  input  logic [DEPTH-1:0] free_vec_i,
  output logic [DEPTH-1:0] free_oh_o,
  output logic [LOG-1:0]   free_idx_o,
  output logic             found_o
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    free_oh_o  = '0;
    free_idx_o = '0;
    found_o    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec_i[i]) begin
        free_oh_o    = '0;
        free_oh_o[i] = 1'b1;
        free_idx_o   = LOG'(i);
        found_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/isq_entry_ctrl.sv
// Issue-queue entry controller: allocation, wakeup, age-selected issue and flush.
// Optional ISQ_WB_BYPASS_EN: enqueuing sources matching the same-cycle writeback are stored ready.
`ifndef ISSUE_QUEUE_DEPTH
`define ISSUE_QUEUE_DEPTH 8
`endif
`ifndef ISSUE_QUEUE_LOG
`define ISSUE_QUEUE_LOG 3
`endif

module isq_entry_ctrl
  import isq_pkg::*;
#(
  parameter int DEPTH     = `ISSUE_QUEUE_DEPTH,
  parameter int LOG       = `ISSUE_QUEUE_LOG,
  parameter int PREG_W    = ISQ_PREG_W,
  parameter int PAYLOAD_W = ISQ_PAYLOAD_W
) (
  input logic             clock,
  input logic             reset_n,
  isq_entry_ctrl_if.slave io
);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     s1_rdy_q, s1_rdy_d;
  logic [DEPTH-1:0]     s2_rdy_q, s2_rdy_d;
  logic [PREG_W-1:0]    s1_tag_q  [DEPTH];
  logic [PREG_W-1:0]    s2_tag_q  [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];

  logic [DEPTH-1:0] free_oh;
  logic [LOG-1:0]   free_idx;
  logic             free_found;

  logic             wb_hit1, wb_hit2, enq_block;
  logic             enq_s1_rdy, enq_s2_rdy;
  logic             enq_fire, deq_fire;
  logic [DEPTH-1:0] wren, clear, rtg, sel;
  logic [LOG-1:0]   sel_idx;
  logic [PAYLOAD_W-1:0] sel_payload;

  isq_free_finder #(.DEPTH(DEPTH), .LOG(LOG)) u_free (
    .free_vec_i (~valid_q),
    .free_oh_o  (free_oh),
    .free_idx_o (free_idx),
    .found_o    (free_found)
  );

  assign wb_hit1 = io.wb_valid && (io.enq_src1_preg == io.wb_preg);
  assign wb_hit2 = io.wb_valid && (io.enq_src2_preg == io.wb_preg);

`ifdef ISQ_WB_BYPASS_EN
  assign enq_block  = 1'b0;
  assign enq_s1_rdy = io.enq_src1_rdy || (io.enq_src1_preg == '0) || wb_hit1;
  assign enq_s2_rdy = io.enq_src2_rdy || (io.enq_src2_preg == '0) || wb_hit2;
`else
  // Without bypass the broadcast would miss the not-yet-valid entry, so hold rename off.
  assign enq_block  = (wb_hit1 && (io.enq_src1_preg != '0)) ||
                      (wb_hit2 && (io.enq_src2_preg != '0));
  assign enq_s1_rdy = io.enq_src1_rdy || (io.enq_src1_preg == '0);
  assign enq_s2_rdy = io.enq_src2_rdy || (io.enq_src2_preg == '0);
`endif

  assign io.enq_ready          = free_found && !io.flush_valid && !enq_block;
  assign io.enq_ptr            = free_idx;
  assign enq_fire              = io.enq_valid && io.enq_ready;
  assign wren                  = enq_fire ? free_oh : '0;
  assign io.iq_entries_wren_oh = wren;

  assign rtg                       = valid_q & s1_rdy_q & s2_rdy_q;
  assign io.iq_entries_valid       = valid_q;
  assign io.iq_entries_ready_to_go = rtg;

  assign sel          = io.oldest_idx_oh & rtg;
  assign io.deq_valid = io.oldest_found && (|sel) && !io.flush_valid;
  assign deq_fire     = io.deq_valid && io.deq_ready;

  always_comb begin
    sel_payload = '0;
    sel_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        sel_payload = sel_payload | payload_q[i];
        sel_idx     = sel_idx | LOG'(i);
      end
    end
  end

  assign io.deq_payload            = sel_payload;
  assign clear                     = deq_fire ? sel : '0;
  assign io.iq_entries_clear_entry = clear;
  assign io.deq_ptr                = deq_fire ? sel_idx : '0;

  // Clear wins over wakeup; enqueue and clear never target the same slot.
  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (io.wb_valid && valid_q[i]) begin
        if (s1_tag_q[i] == io.wb_preg) s1_rdy_d[i] = 1'b1;
        if (s2_tag_q[i] == io.wb_preg) s2_rdy_d[i] = 1'b1;
      end
      if (clear[i]) valid_d[i] = 1'b0;
      if (wren[i]) begin
        valid_d[i]  = 1'b1;
        s1_rdy_d[i] = enq_s1_rdy;
        s2_rdy_d[i] = enq_s2_rdy;
      end
    end
    if (io.flush_valid) valid_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
    end else begin
      valid_q  <= valid_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wren[i]) begin
        s1_tag_q[i]  <= io.enq_src1_preg;
        s2_tag_q[i]  <= io.enq_src2_preg;
        payload_q[i] <= io.enq_payload;
      end
    end
  end

endmodule

// File: tb/tb_isq_entry_ctrl.sv
// Self-checking bench for isq_entry_ctrl: directed scenarios plus a randomized run against a queue model.
module tb_isq_entry_ctrl;
  import isq_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;

  isq_entry_ctrl_if io ();
  isq_entry_ctrl dut (.clock(clock), .reset_n(reset_n), .io(io));

  task automatic idle();
    io.enq_valid = 0; io.enq_src1_preg = '0; io.enq_src2_preg = '0;
    io.enq_src1_rdy = 0; io.enq_src2_rdy = 0; io.enq_payload = '0;
    io.wb_valid = 0; io.wb_preg = '0; io.flush_valid = 0;
    io.oldest_found = 0; io.oldest_idx_oh = '0; io.deq_ready = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    #3;
    total++; if (io.iq_entries_valid !== 8'h00) begin bad++; $display("FAIL rst_valid got=%h want=00", io.iq_entries_valid); end
    total++; if (io.iq_entries_ready_to_go !== 8'h00) begin bad++; $display("FAIL rst_rtg got=%h want=00", io.iq_entries_ready_to_go); end
    total++; if (io.deq_valid !== 1'b0) begin bad++; $display("FAIL rst_deq_valid got=%b want=0", io.deq_valid); end
    total++; if (io.enq_ptr !== 3'd0) begin bad++; $display("FAIL rst_enq_ptr got=%0d want=0", io.enq_ptr); end
    @(negedge clock);
    reset_n = 1;
    tick();
    #2;
    total++; if (io.enq_ready !== 1'b1) begin bad++; $display("FAIL rst_enq_ready got=%b want=1", io.enq_ready); end
  endtask

  task automatic test_wakeup();
    io.enq_valid = 1; io.enq_src1_preg = 6'd5; io.enq_src1_rdy = 0;
    io.enq_src2_preg = 6'd0; io.enq_src2_rdy = 0; io.enq_payload = 64'hCAFE_0000_0000_0005;
    #2;
    total++; if (io.iq_entries_wren_oh !== 8'h01) begin bad++; $display("FAIL wake_wren got=%h want=01", io.iq_entries_wren_oh); end
    tick(); idle(); io.wb_valid = 1; io.wb_preg = 6'd5;
    #2;
    total++; if (io.iq_entries_valid !== 8'h01) begin bad++; $display("FAIL wake_valid got=%h want=01", io.iq_entries_valid); end
    total++; if (io.iq_entries_ready_to_go !== 8'h00) begin bad++; $display("FAIL wake_rtg_early got=%h want=00", io.iq_entries_ready_to_go); end
    tick(); idle(); io.oldest_found = 1; io.oldest_idx_oh = 8'h01; io.deq_ready = 1;
    #2;
    total++; if (io.iq_entries_ready_to_go !== 8'h01) begin bad++; $display("FAIL wake_rtg got=%h want=01", io.iq_entries_ready_to_go); end
    total++; if (io.deq_payload !== 64'hCAFE_0000_0000_0005) begin bad++; $display("FAIL wake_payload got=%h want=cafe000000000005", io.deq_payload); end
    total++; if (io.iq_entries_clear_entry !== 8'h01) begin bad++; $display("FAIL wake_clear got=%h want=01", io.iq_entries_clear_entry); end
    tick(); idle();
    #2;
    total++; if (io.iq_entries_valid !== 8'h00) begin bad++; $display("FAIL wake_drain got=%h want=00", io.iq_entries_valid); end
  endtask

  task automatic test_fill_reuse();
    for (int i = 0; i < 8; i++) begin
      io.enq_valid = 1; io.enq_src1_preg = '0; io.enq_src2_preg = '0;
      io.enq_payload = 64'hA000_0000_0000_0000 | 64'(i);
      #2;
      total++; if (io.enq_ptr !== 3'(i)) begin bad++; $display("FAIL fill_ptr%0d got=%0d want=%0d", i, io.enq_ptr, i); end
      total++; if (io.iq_entries_wren_oh !== 8'(1 << i)) begin bad++; $display("FAIL fill_wren%0d got=%h want=%h", i, io.iq_entries_wren_oh, 8'(1 << i)); end
      tick();
    end
    #2;
    total++; if (io.enq_ready !== 1'b0) begin bad++; $display("FAIL full_enq_ready got=%b want=0", io.enq_ready); end
    total++; if (io.iq_entries_wren_oh !== 8'h00) begin bad++; $display("FAIL full_wren got=%h want=00", io.iq_entries_wren_oh); end
    total++; if (io.iq_entries_valid !== 8'hff) begin bad++; $display("FAIL full_valid got=%h want=ff", io.iq_entries_valid); end
    io.oldest_found = 1; io.oldest_idx_oh = 8'h08; io.deq_ready = 1;
    #2;
    total++; if (io.iq_entries_clear_entry !== 8'h08) begin bad++; $display("FAIL reuse_clear got=%h want=08", io.iq_entries_clear_entry); end
    total++; if (io.deq_ptr !== 3'd3) begin bad++; $display("FAIL reuse_deq_ptr got=%0d want=3", io.deq_ptr); end
    total++; if (io.enq_ready !== 1'b0) begin bad++; $display("FAIL reuse_same_cycle got=%b want=0", io.enq_ready); end
    tick();
    io.oldest_found = 0; io.oldest_idx_oh = '0; io.deq_ready = 0;
    io.enq_payload = 64'hB000_0000_0000_0003;
    #2;
    total++; if (io.enq_ptr !== 3'd3) begin bad++; $display("FAIL reuse_ptr got=%0d want=3", io.enq_ptr); end
    total++; if (io.iq_entries_wren_oh !== 8'h08) begin bad++; $display("FAIL reuse_wren got=%h want=08", io.iq_entries_wren_oh); end
    tick(); idle();
    #2;
    total++; if (io.iq_entries_valid !== 8'hff) begin bad++; $display("FAIL reuse_valid got=%h want=ff", io.iq_entries_valid); end
  endtask

  task automatic test_select();
    io.oldest_found = 1; io.oldest_idx_oh = 8'h04; io.deq_ready = 0;
    #2;
    total++; if (io.deq_valid !== 1'b1) begin bad++; $display("FAIL sel_deq_valid got=%b want=1", io.deq_valid); end
    total++; if (io.iq_entries_clear_entry !== 8'h00) begin bad++; $display("FAIL sel_hold_clear got=%h want=00", io.iq_entries_clear_entry); end
    io.deq_ready = 1;
    #1;
    total++; if (io.iq_entries_clear_entry !== 8'h04) begin bad++; $display("FAIL sel_clear got=%h want=04", io.iq_entries_clear_entry); end
    total++; if (io.deq_ptr !== 3'd2) begin bad++; $display("FAIL sel_deq_ptr got=%0d want=2", io.deq_ptr); end
    total++; if (io.deq_payload !== 64'hA000_0000_0000_0002) begin bad++; $display("FAIL sel_payload got=%h want=a000000000000002", io.deq_payload); end
    tick(); idle();
    #2;
    total++; if (io.iq_entries_valid !== 8'hfb) begin bad++; $display("FAIL sel_valid got=%h want=fb", io.iq_entries_valid); end
  endtask

  task automatic test_flush();
    io.flush_valid = 1; io.enq_valid = 1; io.deq_ready = 1;
    io.oldest_found = 1; io.oldest_idx_oh = 8'h01;
    #2;
    total++; if (io.enq_ready !== 1'b0) begin bad++; $display("FAIL flush_enq_ready got=%b want=0", io.enq_ready); end
    total++; if (io.iq_entries_wren_oh !== 8'h00) begin bad++; $display("FAIL flush_wren got=%h want=00", io.iq_entries_wren_oh); end
    total++; if (io.iq_entries_clear_entry !== 8'h00) begin bad++; $display("FAIL flush_clear got=%h want=00", io.iq_entries_clear_entry); end
    total++; if (io.deq_valid !== 1'b0) begin bad++; $display("FAIL flush_deq_valid got=%b want=0", io.deq_valid); end
    tick(); idle();
    #2;
    total++; if (io.iq_entries_valid !== 8'h00) begin bad++; $display("FAIL flush_valid got=%h want=00", io.iq_entries_valid); end
  endtask

  task automatic test_bypass();
    io.enq_valid = 1; io.enq_src1_preg = 6'd9; io.enq_src1_rdy = 0;
    io.enq_src2_preg = 6'd0; io.enq_src2_rdy = 0;
    io.wb_valid = 1; io.wb_preg = 6'd9;
    #2;
`ifdef ISQ_WB_BYPASS_EN
    total++; if (io.enq_ready !== 1'b1) begin bad++; $display("FAIL byp_enq_ready got=%b want=1", io.enq_ready); end
    total++; if (io.iq_entries_wren_oh !== 8'h01) begin bad++; $display("FAIL byp_wren got=%h want=01", io.iq_entries_wren_oh); end
    tick(); idle();
    #2;
    total++; if (io.iq_entries_ready_to_go !== 8'h01) begin bad++; $display("FAIL byp_rtg got=%h want=01", io.iq_entries_ready_to_go); end
    io.flush_valid = 1;
    tick(); idle();
`else
    total++; if (io.enq_ready !== 1'b0) begin bad++; $display("FAIL byp_enq_ready got=%b want=0", io.enq_ready); end
    total++; if (io.iq_entries_wren_oh !== 8'h00) begin bad++; $display("FAIL byp_wren got=%h want=00", io.iq_entries_wren_oh); end
    tick(); idle();
    #2;
    total++; if (io.iq_entries_valid !== 8'h00) begin bad++; $display("FAIL byp_valid got=%h want=00", io.iq_entries_valid); end
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      io.enq_valid = 1; io.enq_src1_preg = '0; io.enq_src2_preg = '0;
      io.enq_payload = 64'(i);
      tick();
    end
    idle(); io.oldest_found = 1; io.oldest_idx_oh = 8'h01; io.deq_ready = 1;
    #2;
    total++; if (io.iq_entries_valid !== 8'h0f) begin bad++; $display("FAIL ar_pre_valid got=%h want=0f", io.iq_entries_valid); end
    total++; if (io.deq_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_deq got=%b want=1", io.deq_valid); end
    reset_n = 0;
    #1;
    total++; if (io.iq_entries_valid !== 8'h00) begin bad++; $display("FAIL ar_valid got=%h want=00", io.iq_entries_valid); end
    total++; if (io.iq_entries_ready_to_go !== 8'h00) begin bad++; $display("FAIL ar_rtg got=%h want=00", io.iq_entries_ready_to_go); end
    total++; if (io.deq_valid !== 1'b0) begin bad++; $display("FAIL ar_deq_valid got=%b want=0", io.deq_valid); end
    total++; if (io.iq_entries_clear_entry !== 8'h00) begin bad++; $display("FAIL ar_clear got=%h want=00", io.iq_entries_clear_entry); end
    total++; if (io.enq_ptr !== 3'd0) begin bad++; $display("FAIL ar_enq_ptr got=%0d want=0", io.enq_ptr); end
    total++; if (io.enq_ready !== 1'b1) begin bad++; $display("FAIL ar_enq_ready got=%b want=1", io.enq_ready); end
    idle();
    @(negedge clock);
    reset_n = 1;
    tick();
  endtask

  task automatic test_random();
    bit          mv [8];
    bit          mr1 [8];
    bit          mr2 [8];
    logic [5:0]  mt1 [8];
    logic [5:0]  mt2 [8];
    logic [63:0] mp [8];
    int          age [$];
    bit          ev, r1, r2, wv, fl, dr, of, hasfree, conf, hit;
    logic [5:0]  t1, t2, wp;
    logic [63:0] pl;
    logic [7:0]  oh, e_valid, e_rtg, sel, e_wren, e_clr;
    int          pick, fidx;
    bit          e_er, e_dv;
    logic [2:0]  e_ptr, e_dptr;

    for (int i = 0; i < 8; i++) begin mv[i] = 0; mr1[i] = 0; mr2[i] = 0; end
    idle(); io.flush_valid = 1; tick(); idle();

    for (int c = 0; c < 400; c++) begin
      ev = ($urandom % 3) != 0;
      t1 = 6'($urandom_range(0, 7)); t2 = 6'($urandom_range(0, 7));
      r1 = 1'($urandom % 2); r2 = 1'($urandom % 2);
      pl = {$urandom, $urandom};
      wv = 1'($urandom % 2); wp = 6'($urandom_range(0, 7));
      fl = ($urandom % 40) == 0;
      dr = ($urandom % 4) != 0;
      of = age.size() > 0;
      pick = 0;
      oh = '0;
      if (of) begin
        pick = age[0];
        if (($urandom % 4) != 0) begin
          hit = 0;
          for (int k = 0; k < age.size(); k++)
            if (!hit && mv[age[k]] && mr1[age[k]] && mr2[age[k]]) begin pick = age[k]; hit = 1; end
        end else begin
          pick = age[$urandom_range(0, age.size() - 1)];
        end
        oh[pick] = 1'b1;
      end else begin
        oh = 8'(1 << $urandom_range(0, 7));
      end

      io.enq_valid = ev; io.enq_src1_preg = t1; io.enq_src2_preg = t2;
      io.enq_src1_rdy = r1; io.enq_src2_rdy = r2; io.enq_payload = pl;
      io.wb_valid = wv; io.wb_preg = wp; io.flush_valid = fl;
      io.oldest_found = of; io.oldest_idx_oh = oh; io.deq_ready = dr;

      e_valid = '0; e_rtg = '0;
      for (int i = 0; i < 8; i++) begin
        e_valid[i] = mv[i];
        e_rtg[i]   = mv[i] && mr1[i] && mr2[i];
      end
      hasfree = 0; fidx = 0;
      for (int i = 7; i >= 0; i--) if (!mv[i]) begin hasfree = 1; fidx = i; end
      conf = 0;
`ifndef ISQ_WB_BYPASS_EN
      conf = wv && ((t1 != 0 && t1 == wp) || (t2 != 0 && t2 == wp));
`endif
      e_er   = hasfree && !fl && !conf;
      e_ptr  = hasfree ? 3'(fidx) : 3'd0;
      e_wren = (ev && e_er) ? 8'(1 << fidx) : 8'h00;
      sel    = oh & e_rtg;
      e_dv   = of && (sel != 0) && !fl;
      e_clr  = (e_dv && dr) ? sel : 8'h00;
      e_dptr = (e_clr != 0) ? 3'(pick) : 3'd0;

      #2;
      total++; if (io.iq_entries_valid !== e_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%h want=%h", c, io.iq_entries_valid, e_valid); end
      total++; if (io.iq_entries_ready_to_go !== e_rtg) begin bad++; $display("FAIL rnd_rtg c=%0d got=%h want=%h", c, io.iq_entries_ready_to_go, e_rtg); end
      total++; if (io.enq_ready !== e_er) begin bad++; $display("FAIL rnd_enq_ready c=%0d got=%b want=%b", c, io.enq_ready, e_er); end
      total++; if (io.enq_ptr !== e_ptr) begin bad++; $display("FAIL rnd_enq_ptr c=%0d got=%0d want=%0d", c, io.enq_ptr, e_ptr); end
      total++; if (io.iq_entries_wren_oh !== e_wren) begin bad++; $display("FAIL rnd_wren c=%0d got=%h want=%h", c, io.iq_entries_wren_oh, e_wren); end
      total++; if (io.deq_valid !== e_dv) begin bad++; $display("FAIL rnd_deq_valid c=%0d got=%b want=%b", c, io.deq_valid, e_dv); end
      total++; if (io.iq_entries_clear_entry !== e_clr) begin bad++; $display("FAIL rnd_clear c=%0d got=%h want=%h", c, io.iq_entries_clear_entry, e_clr); end
      total++; if (io.deq_ptr !== e_dptr) begin bad++; $display("FAIL rnd_deq_ptr c=%0d got=%0d want=%0d", c, io.deq_ptr, e_dptr); end
      if (e_dv) begin
        total++; if (io.deq_payload !== mp[pick]) begin bad++; $display("FAIL rnd_payload c=%0d got=%h want=%h", c, io.deq_payload, mp[pick]); end
      end

      tick();

      if (fl) begin
        for (int i = 0; i < 8; i++) mv[i] = 0;
        age.delete();
      end else begin
        if (wv)
          for (int i = 0; i < 8; i++)
            if (mv[i]) begin
              if (mt1[i] == wp) mr1[i] = 1;
              if (mt2[i] == wp) mr2[i] = 1;
            end
        if (e_clr != 0) begin
          mv[pick] = 0;
          hit = 0;
          for (int k = 0; k < age.size(); k++)
            if (!hit && age[k] == pick) begin age.delete(k); hit = 1; end
        end
        if (e_wren != 0) begin
          mv[fidx] = 1; mt1[fidx] = t1; mt2[fidx] = t2; mp[fidx] = pl;
          mr1[fidx] = r1 || (t1 == 0);
          mr2[fidx] = r2 || (t2 == 0);
`ifdef ISQ_WB_BYPASS_EN
          if (wv && t1 == wp) mr1[fidx] = 1;
          if (wv && t2 == wp) mr2[fidx] = 1;
`endif
          age.push_back(fidx);
        end
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wakeup();
    test_fill_reuse();
    test_select();
    test_flush();
    test_bypass();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
